// File: rtl/multicycle_sequencer_if.sv
// Bundle of datapath strobes, memory handshakes and status between the
// multicycle sequencer (master) and the datapath/memory side (slave).
interface multicycle_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             run;
    logic [WIDTH-1:0] instruction;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             memtoread;
    logic             memwrite;
    logic             irwrite;
    logic             pcwrite;
    logic             pcsrc;
    logic             alusrc;
    logic [3:0]       aluop;
    logic             memtoreg;
    logic             regwrite;
    logic             illegal;
    logic             buserr;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instruction, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, memtoread, memwrite, irwrite,
        output pcwrite, pcsrc, alusrc, aluop, memtoreg, regwrite,
        output illegal, buserr, retired
    );

    modport slave (
        output run, instruction, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, memtoread, memwrite, irwrite,
        input  pcwrite, pcsrc, alusrc, aluop, memtoreg, regwrite,
        input  illegal, buserr, retired
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32 add/sub/and/or/lw/sw/beq subset:
// fetch/decode/exec/mem/wb over one ALU, with illegal and bus-timeout traps.
module multicycle_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic clk,
    input logic rst,
    multicycle_sequencer_if.master bus
);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NONE = 4'b1111;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    typedef enum logic [1:0] {
        C_R, C_BEQ, C_LW, C_SW
    } cls_t;

    state_t           state;
    cls_t             cls;
    logic [3:0]       op;
    logic [WW-1:0]    wcnt;
    logic             illegal;
    logic             buserr;
    logic [CNT_W-1:0] retired;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;
    logic       legal;
    cls_t       dcls;
    logic [3:0] dop;
    logic       limit;
    logic       unused_bits;

    assign opcode = bus.instruction[6:0];
    assign f3     = bus.instruction[14:12];
    assign f7b5   = bus.instruction[30];
    assign limit  = (wcnt == WW'(TIMEOUT - 1));
    assign unused_bits = ^{bus.instruction[WIDTH-1:31],
                           bus.instruction[29:15],
                           bus.instruction[11:7]};

    always_comb begin
        legal = 1'b0;
        dcls  = C_R;
        dop   = OP_NONE;
        case (opcode)
            7'b1100011: begin legal = 1'b1; dcls = C_BEQ; dop = OP_SUB; end
            7'b0000011: begin legal = 1'b1; dcls = C_LW;  dop = OP_ADD; end
            7'b0100011: begin legal = 1'b1; dcls = C_SW;  dop = OP_ADD; end
            7'b0110011: begin
                case ({f3, f7b5})
                    4'b000_0: begin legal = 1'b1; dop = OP_ADD; end
                    4'b000_1: begin legal = 1'b1; dop = OP_SUB; end
                    4'b110_0: begin legal = 1'b1; dop = OP_OR;  end
                    4'b111_0: begin legal = 1'b1; dop = OP_AND; end
                    default:  legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            cls     <= C_R;
            op      <= OP_NONE;
            wcnt    <= '0;
            illegal <= 1'b0;
            buserr  <= 1'b0;
            retired <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!bus.run) begin
                        wcnt <= '0;
                    end else if (bus.imem_ready) begin
                        wcnt  <= '0;
                        state <= DECODE;
                    end else if (limit) begin
                        wcnt   <= '0;
                        buserr <= 1'b1;
                        state  <= TRAP;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                DECODE: begin
                    if (legal) begin
                        cls   <= dcls;
                        op    <= dop;
                        state <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= TRAP;
                    end
                end
                EXEC: begin
                    unique case (cls)
                        C_BEQ: begin
                            retired <= retired + CNT_W'(1);
                            state   <= FETCH;
                        end
                        C_R:     state <= WB;
                        default: state <= MEM;
                    endcase
                end
                MEM: begin
                    // READY on the limit cycle still completes the access
                    if (bus.dmem_ready) begin
                        wcnt <= '0;
                        if (cls == C_SW) begin
                            retired <= retired + CNT_W'(1);
                            state   <= FETCH;
                        end else begin
                            state <= WB;
                        end
                    end else if (limit) begin
                        wcnt   <= '0;
                        buserr <= 1'b1;
                        state  <= TRAP;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                WB: begin
                    retired <= retired + CNT_W'(1);
                    state   <= FETCH;
                end
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so an aborted instruction leaves nothing asserted.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.memtoread = 1'b0;
        bus.memwrite  = 1'b0;
        bus.irwrite   = 1'b0;
        bus.pcwrite   = 1'b0;
        bus.pcsrc     = 1'b0;
        bus.alusrc    = 1'b0;
        bus.aluop     = OP_NONE;
        bus.memtoreg  = 1'b0;
        bus.regwrite  = 1'b0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    bus.imem_req = bus.run;
                    bus.irwrite  = bus.run & bus.imem_ready;
                end
                EXEC: begin
                    bus.aluop  = op;
                    bus.alusrc = (cls == C_LW) || (cls == C_SW);
                    if (cls == C_BEQ) begin
                        bus.pcwrite = 1'b1;
                        bus.pcsrc   = bus.zero;
                    end
                end
                MEM: begin
                    bus.dmem_req  = 1'b1;
                    bus.alusrc    = 1'b1;
                    bus.aluop     = OP_ADD;
                    bus.memtoread = (cls == C_LW);
                    bus.memwrite  = (cls == C_SW);
                    bus.pcwrite   = (cls == C_SW) && bus.dmem_ready;
                end
                WB: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = (cls == C_LW);
                    bus.pcwrite  = 1'b1;
                end
                DECODE, TRAP: ;
                default: ;
            endcase
        end
    end

    assign bus.illegal = illegal;
    assign bus.buserr  = buserr;
    assign bus.retired = retired;
endmodule
